timer_apb_regs: RTL and testbench



---
 rtl/timer_apb_regs.sv | 180 ++++++++++++++++++
 tb/tb_timer_apb_regs.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_regs.sv
// APB responder and register file (TCR/TDR/TCNT/TSR) for the 8-bit timer.
// Define TIMER_INT_EN to add the TIER register at 8'h04 and the registered irq output.
module timer_apb_regs #(
    parameter int WAIT_STATES = 1
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] tdr,
    output logic       load,
    output logic       cnt_en,
    output logic       cnt_dw,
    output logic [1:0] clk_sel,
    input  logic [7:0] cnt,
    input  logic       tmr_ovf,
    input  logic       tmr_udf
`ifdef TIMER_INT_EN
    ,
    output logic       irq
`endif
);

    localparam logic [7:0] A_TCR  = 8'h00;
    localparam logic [7:0] A_TDR  = 8'h01;
    localparam logic [7:0] A_TCNT = 8'h02;
    localparam logic [7:0] A_TSR  = 8'h03;
`ifdef TIMER_INT_EN
    localparam logic [7:0] A_TIER = 8'h04;
`endif
    localparam logic [1:0] WS = WAIT_STATES[1:0];

    // SETUP is the first access cycle after a setup phase was seen; ACCESS covers
    // the remaining wait cycles. wcnt counts wait cycles already spent.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] wcnt;
    logic [1:0] wcnt_nxt;

    logic       tcr_en;
    logic       tcr_dw;
    logic [1:0] tcr_clk;
    logic       tsr_ovf;
    logic       tsr_udf;
`ifdef TIMER_INT_EN
    logic [1:0] tier;
`endif

    logic       reg_hit;
    logic       bus_err;
    logic [7:0] rd_mux;
    logic       wr_commit;
    logic       wr_tcr;
    logic       wr_tdr;
    logic       wr_tsr;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state <= ST_IDLE;
            wcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE: begin
                wcnt_nxt = 2'd0;
                if (psel && !penable) state_nxt = ST_SETUP;
            end
            ST_SETUP, ST_ACCESS: begin
                if (pready) begin
                    state_nxt = (psel && !penable) ? ST_SETUP : ST_IDLE;
                    wcnt_nxt  = 2'd0;
                end else if (psel && penable) begin
                    state_nxt = ST_ACCESS;
                    wcnt_nxt  = wcnt + 2'd1;
                end else if (psel) begin
                    state_nxt = ST_SETUP;
                    wcnt_nxt  = 2'd0;
                end else begin
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = 2'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                wcnt_nxt  = 2'd0;
            end
        endcase
    end

    // Handshake: a transfer completes in the single cycle where psel, penable and
    // pready are all high; prdata/pslverr are meaningful only in that cycle.
    always_comb begin
        pready = 1'b0;
        if ((state == ST_SETUP || state == ST_ACCESS) && psel && penable && wcnt == WS)
            pready = 1'b1;
    end

    always_comb begin
        reg_hit = 1'b1;
        rd_mux  = 8'h00;
        case (paddr)
            A_TCR:  rd_mux = {2'b00, tcr_dw, tcr_en, 2'b00, tcr_clk};
            A_TDR:  rd_mux = tdr;
            A_TCNT: rd_mux = cnt;
            A_TSR:  rd_mux = {6'b000000, tsr_udf, tsr_ovf};
`ifdef TIMER_INT_EN
            A_TIER: rd_mux = {6'b000000, tier};
`endif
            default: reg_hit = 1'b0;
        endcase
    end

    assign bus_err   = !reg_hit || (pwrite && paddr == A_TCNT);
    assign pslverr   = pready && bus_err;
    assign prdata    = (pready && !pwrite && !bus_err) ? rd_mux : 8'h00;

    assign wr_commit = psel && penable && pready && pwrite && !bus_err;
    assign wr_tcr    = wr_commit && paddr == A_TCR;
    assign wr_tdr    = wr_commit && paddr == A_TDR;
    assign wr_tsr    = wr_commit && paddr == A_TSR;

    // Status: a pulse sets the bit; writing 0 clears it, but a same-cycle pulse wins.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tdr     <= 8'h00;
            tcr_en  <= 1'b0;
            tcr_dw  <= 1'b0;
            tcr_clk <= 2'b00;
            load    <= 1'b0;
            tsr_ovf <= 1'b0;
            tsr_udf <= 1'b0;
        end else begin
            load <= wr_tcr && pwdata[7];
            if (wr_tcr) begin
                tcr_en  <= pwdata[4];
                tcr_dw  <= pwdata[5];
                tcr_clk <= pwdata[1:0];
            end
            if (wr_tdr) tdr <= pwdata;
            tsr_ovf <= tmr_ovf || (tsr_ovf && !(wr_tsr && !pwdata[0]));
            tsr_udf <= tmr_udf || (tsr_udf && !(wr_tsr && !pwdata[1]));
        end
    end

`ifdef TIMER_INT_EN
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tier <= 2'b00;
            irq  <= 1'b0;
        end else begin
            if (wr_commit && paddr == A_TIER) tier <= pwdata[1:0];
            irq <= |({tsr_udf, tsr_ovf} & tier);
        end
    end
`endif

    assign cnt_en  = tcr_en;
    assign cnt_dw  = tcr_dw;
    assign clk_sel = tcr_clk;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed bench for timer_apb_regs (WAIT_STATES=1); define TIMER_INT_EN to also cover TIER/irq.
module tb_timer_apb_regs;

  localparam int WS = 1;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] tdr;
  logic       load;
  logic       cnt_en;
  logic       cnt_dw;
  logic [1:0] clk_sel;
  logic [7:0] cnt;
  logic       tmr_ovf;
  logic       tmr_udf;
`ifdef TIMER_INT_EN
  logic       irq;
`endif

  int checks = 0;
  int failures = 0;

  timer_apb_regs #(.WAIT_STATES(WS)) dut (
    .pclk(pclk),
    .presetn(presetn),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .tdr(tdr),
    .load(load),
    .cnt_en(cnt_en),
    .cnt_dw(cnt_dw),
    .clk_sel(clk_sel),
    .cnt(cnt),
    .tmr_ovf(tmr_ovf),
    .tmr_udf(tmr_udf)
`ifdef TIMER_INT_EN
    , .irq(irq)
`endif
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One APB transfer, entered and left at posedge+1; optionally pulses tmr_udf
  // in the completing cycle.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                     input logic udf_at_done, output logic [7:0] rd, output logic err,
                     output int ncyc);
    int guard;
    logic done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    tick();
    penable = 1'b1;
    ncyc = 2; guard = 0; done = 1'b0; rd = 8'h00; err = 1'b0;
    while (!done) begin
      @(negedge pclk);
      if (pready) begin
        rd = prdata; err = pslverr; done = 1'b1;
        if (udf_at_done) tmr_udf = 1'b1;
      end else if (guard >= 8) begin
        checks++;
        failures++;
        $error("FAIL timeout addr=%0h observed=no_pready expected=pready", addr);
        done = 1'b1;
      end else begin
        tick();
        ncyc++; guard++;
      end
    end
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tmr_udf = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data, input logic exp_err);
    logic [7:0] rd;
    logic err;
    int n;
    apb(1'b1, addr, data, 1'b0, rd, err, n);
    check($sformatf("wr%0h.err", addr), {7'd0, err}, {7'd0, exp_err});
    check($sformatf("wr%0h.cycles", addr), n[7:0], 8'(2 + WS));
  endtask

  task automatic read_reg(input logic [7:0] addr, input logic [7:0] exp, input logic exp_err);
    logic [7:0] rd;
    logic err;
    int n;
    apb(1'b0, addr, 8'h00, 1'b0, rd, err, n);
    check($sformatf("rd%0h.data", addr), rd, exp);
    check($sformatf("rd%0h.err", addr), {7'd0, err}, {7'd0, exp_err});
    check($sformatf("rd%0h.cycles", addr), n[7:0], 8'(2 + WS));
  endtask

  initial begin
    logic [7:0] rd;
    logic err;
    int n;

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; cnt = 8'h00; tmr_ovf = 1'b0; tmr_udf = 1'b0;
    tick();
    tick();
    @(negedge pclk);
    check("rst.pready", {7'd0, pready}, 8'h00);
    check("rst.pslverr", {7'd0, pslverr}, 8'h00);
    check("rst.prdata", prdata, 8'h00);
    check("rst.tdr", tdr, 8'h00);
    check("rst.load", {7'd0, load}, 8'h00);
    check("rst.ctrl", {4'd0, cnt_dw, cnt_en, clk_sel}, 8'h00);
    tick();
    presetn = 1'b1;
    tick();

    // Reset values via the bus, back to back
    read_reg(8'h00, 8'h00, 1'b0);
    read_reg(8'h01, 8'h00, 1'b0);
    read_reg(8'h02, 8'h00, 1'b0);
    read_reg(8'h03, 8'h00, 1'b0);

    // Setup-less penable is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("nosetup.pready", {7'd0, pready}, 8'h00);
      tick();
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    read_reg(8'h01, 8'h00, 1'b0);

    // TDR, load strobe, control fields
    write_reg(8'h01, 8'h64, 1'b0);
    check("tdr.out", tdr, 8'h64);
    write_reg(8'h00, 8'h80, 1'b0);
    @(negedge pclk);
    check("load.high", {7'd0, load}, 8'h01);
    tick();
    @(negedge pclk);
    check("load.low", {7'd0, load}, 8'h00);
    tick();
    read_reg(8'h00, 8'h00, 1'b0);
    write_reg(8'h00, 8'h10, 1'b0);
    @(negedge pclk);
    check("tcr10.ctrl", {4'd0, cnt_dw, cnt_en, clk_sel}, 8'h04);
    check("tcr10.noload", {7'd0, load}, 8'h00);
    tick();
    read_reg(8'h01, 8'h64, 1'b0);
    write_reg(8'h00, 8'hFF, 1'b0);
    @(negedge pclk);
    check("tcrff.load", {7'd0, load}, 8'h01);
    tick();
    read_reg(8'h00, 8'h33, 1'b0);
    write_reg(8'h00, 8'h2E, 1'b0);
    @(negedge pclk);
    check("tcr2e.ctrl", {4'd0, cnt_dw, cnt_en, clk_sel}, 8'h0A);
    tick();
    read_reg(8'h00, 8'h22, 1'b0);

    // Sticky status
    tmr_ovf = 1'b1;
    tick();
    tmr_ovf = 1'b0;
    read_reg(8'h03, 8'h01, 1'b0);
    write_reg(8'h03, 8'h01, 1'b0);
    read_reg(8'h03, 8'h01, 1'b0);
    write_reg(8'h03, 8'h00, 1'b0);
    read_reg(8'h03, 8'h00, 1'b0);

    // Set beats clear in the same cycle
    tmr_ovf = 1'b1;
    tick();
    tmr_ovf = 1'b0;
    apb(1'b1, 8'h03, 8'h00, 1'b1, rd, err, n);
    check("setwins.err", {7'd0, err}, 8'h00);
    read_reg(8'h03, 8'h02, 1'b0);
    write_reg(8'h03, 8'h00, 1'b0);
    read_reg(8'h03, 8'h00, 1'b0);

    // Live counter and error responses
    cnt = 8'hA5;
    read_reg(8'h02, 8'hA5, 1'b0);
    write_reg(8'h02, 8'h55, 1'b1);
    read_reg(8'h07, 8'h00, 1'b1);
    write_reg(8'h07, 8'h11, 1'b1);
`ifndef TIMER_INT_EN
    read_reg(8'h04, 8'h00, 1'b1);
`endif
    read_reg(8'h00, 8'h22, 1'b0);
    read_reg(8'h01, 8'h64, 1'b0);
    read_reg(8'h03, 8'h00, 1'b0);
    check("err.tdr", tdr, 8'h64);

`ifdef TIMER_INT_EN
    write_reg(8'h04, 8'h01, 1'b0);
    read_reg(8'h04, 8'h01, 1'b0);
    tmr_ovf = 1'b1;
    tick();
    tmr_ovf = 1'b0;
    @(negedge pclk);
    check("irq.lag", {7'd0, irq}, 8'h00);
    tick();
    @(negedge pclk);
    check("irq.set", {7'd0, irq}, 8'h01);
    tick();
    write_reg(8'h03, 8'h00, 1'b0);
    tick();
    @(negedge pclk);
    check("irq.clr", {7'd0, irq}, 8'h00);
    tick();
`endif

    // Reset during the wait cycle of a TDR write aborts it
    write_reg(8'h01, 8'h00, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hAA;
    tick();
    penable = 1'b1;
    presetn = 1'b0;
    @(negedge pclk);
    check("abort.pready", {7'd0, pready}, 8'h00);
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; presetn = 1'b1;
    @(negedge pclk);
    check("abort.tdr", tdr, 8'h00);
    tick();
    read_reg(8'h01, 8'h00, 1'b0);
    read_reg(8'h00, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
